// File: rtl/recepcao_pkg.sv
// Shared types, constants and helpers for the measurement-link receiver.
package recepcao_pkg;

    localparam logic [7:0] ASCII_0        = 8'h30;
    localparam logic [7:0] ASCII_9        = 8'h39;
    localparam int         DIGITOS_PACOTE = 8;

    typedef enum logic [3:0] {
        AGUARDA = 4'd0,
        DIGITO  = 4'd1,
        PUBLICA = 4'd2,
        ERRO    = 4'd3
    } estado_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DADOS = 2'd2,
        RX_STOP  = 2'd3
    } rx_estado_t;

    function automatic logic eh_digito(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    // tens*10 + units via shifts; 0..99 always fits in 7 bits
    function automatic logic [6:0] junta_campo(input logic [3:0] t, input logic [3:0] u);
        logic [6:0] t7;
        t7 = {3'b000, t};
        return (t7 << 3'd3) + (t7 << 3'd1) + {3'b000, u};
    endfunction

endpackage

// File: rtl/rx_serial_8n1.sv
// 8N1 byte receiver: input synchroniser, baud counter, LSB-first shift register.
module rx_serial_8n1
    import recepcao_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int N_SYNC       = 2
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] dado_o,
    output logic       byte_ok_o,
    output logic       byte_err_o
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  FIM_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  MEIO_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [N_SYNC-1:0] sync_q;
    logic              ant_q;
    rx_estado_t        estado_q, estado_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        nbit_q, nbit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        dado_q, dado_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic              rx_s;
    logic              descida_s;

    assign rx_s      = sync_q[N_SYNC-1];
    assign descida_s = ant_q & ~rx_s;

    // State registers; synchroniser idles high so reset never fakes a start bit
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            sync_q   <= '1;
            ant_q    <= 1'b1;
            estado_q <= RX_IDLE;
            cnt_q    <= '0;
            nbit_q   <= 3'd0;
            shift_q  <= 8'h00;
            dado_q   <= 8'h00;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[N_SYNC-2:0], rx_i};
            ant_q    <= rx_s;
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            nbit_q   <= nbit_d;
            shift_q  <= shift_d;
            dado_q   <= dado_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    // Next-state: half-bit wait validates the start bit, then one sample per bit period
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        nbit_d   = nbit_q;
        shift_d  = shift_q;
        dado_d   = dado_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        case (estado_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (descida_s) begin
                    estado_d = RX_START;
                end else begin
                    estado_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == MEIO_BIT) begin
                    cnt_d  = '0;
                    nbit_d = 3'd0;
                    if (rx_s) begin
                        estado_d = RX_IDLE;
                    end else begin
                        estado_d = RX_DADOS;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DADOS: begin
                if (cnt_q == FIM_BIT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    nbit_d  = nbit_q + 3'd1;
                    if (nbit_q == 3'd7) begin
                        estado_d = RX_STOP;
                    end else begin
                        estado_d = RX_DADOS;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FIM_BIT) begin
                    cnt_d    = '0;
                    estado_d = RX_IDLE;
                    if (rx_s) begin
                        ok_d   = 1'b1;
                        dado_d = shift_q;
                    end else begin
                        err_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                estado_d = RX_IDLE;
                cnt_d    = '0;
            end
        endcase
    end

    assign dado_o     = dado_q;
    assign byte_ok_o  = ok_q;
    assign byte_err_o = err_q;

endmodule

// File: rtl/recepcao_medida_fd.sv
// Measurement-link receiver: turns 8-digit ASCII packets into temperature/humidity words.
module recepcao_medida_fd
    import recepcao_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int N_SYNC       = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_serial,
    output logic [15:0] temperatura,
    output logic [15:0] umidade,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam logic [2:0] IDX_ULTIMO = 3'(DIGITOS_PACOTE - 1);

    logic [7:0]      dado_s;
    logic            byte_ok_s;
    logic            byte_err_s;
    logic [3:0]      digito_s;

    estado_t         estado_q, estado_d;
    logic [2:0]      idx_q, idx_d;
    logic [3:0]      dig_q, dig_d;
    logic [3:0]      dezena_q, dezena_d;
    logic [3:0][6:0] campo_q, campo_d;
    logic [15:0]     temp_q, temp_d;
    logic [15:0]     umid_q, umid_d;
    logic            pronto_q, pronto_d;
    logic            erro_q, erro_d;

    rx_serial_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .N_SYNC       (N_SYNC)
    ) u_rx (
        .clock_i    (clock),
        .reset_i    (reset),
        .rx_i       (rx_serial),
        .dado_o     (dado_s),
        .byte_ok_o  (byte_ok_s),
        .byte_err_o (byte_err_s)
    );

    // Low nibble of an ASCII digit equals its value, so only that is kept
    assign digito_s = dig_q;

    // Assembler registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= AGUARDA;
            idx_q    <= 3'd0;
            dig_q    <= 4'd0;
            dezena_q <= 4'd0;
            campo_q  <= '0;
            temp_q   <= 16'h0000;
            umid_q   <= 16'h0000;
            pronto_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            dig_q    <= dig_d;
            dezena_q <= dezena_d;
            campo_q  <= campo_d;
            temp_q   <= temp_d;
            umid_q   <= umid_d;
            pronto_q <= pronto_d;
            erro_q   <= erro_d;
        end
    end

    // Words are published on the edge that leaves the 8th DIGITO, so pronto and data move together
    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        dig_d    = dig_q;
        dezena_d = dezena_q;
        campo_d  = campo_q;
        temp_d   = temp_q;
        umid_d   = umid_q;
        pronto_d = 1'b0;
        erro_d   = 1'b0;
        case (estado_q)
            AGUARDA: begin
                if (byte_ok_s) begin
                    dig_d = dado_s[3:0];
                    if (eh_digito(dado_s)) begin
                        estado_d = DIGITO;
                    end else begin
                        estado_d = ERRO;
                    end
                end else if (byte_err_s) begin
                    estado_d = ERRO;
                end else begin
                    estado_d = AGUARDA;
                end
            end
            DIGITO: begin
                if (!idx_q[0]) begin
                    dezena_d = digito_s;
                end else begin
                    campo_d[idx_q[2:1]] = junta_campo(dezena_q, digito_s);
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == IDX_ULTIMO) begin
                    temp_d   = {1'b0, campo_q[0], 1'b0, campo_q[1]};
                    umid_d   = {1'b0, campo_q[2], 1'b0, junta_campo(dezena_q, digito_s)};
                    pronto_d = 1'b1;
                    estado_d = PUBLICA;
                end else begin
                    estado_d = AGUARDA;
                end
            end
            PUBLICA: begin
                idx_d    = 3'd0;
                estado_d = AGUARDA;
            end
            ERRO: begin
                erro_d   = 1'b1;
                idx_d    = 3'd0;
                estado_d = AGUARDA;
            end
            default: begin
                idx_d    = 3'd0;
                estado_d = AGUARDA;
            end
        endcase
    end

    assign temperatura = temp_q;
    assign umidade     = umid_q;
    assign pronto      = pronto_q;
    assign erro        = erro_q;
    assign db_estado   = estado_q;

endmodule

// File: tb/tb_recepcao_medida_fd.sv
// Scoreboard bench for recepcao_medida_fd: serial packets in, published words checked on pronto.
module tb_recepcao_medida_fd;
    import recepcao_pkg::*;

    localparam int CPB = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx_serial = 1'b1;
    logic [15:0] temperatura;
    logic [15:0] umidade;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    int n_vec = 0;
    int n_err = 0;
    int pronto_cnt = 0;
    int erro_cnt = 0;
    int exp_pronto = 0;
    int exp_erro = 0;
    logic [31:0] sb_q[$];
    logic [15:0] ult_temp = 16'h0000;
    logic [15:0] ult_umid = 16'h0000;

    always #5 clock = ~clock;

    recepcao_medida_fd #(
        .CLKS_PER_BIT (CPB),
        .N_SYNC       (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_serial   (rx_serial),
        .temperatura (temperatura),
        .umidade     (umidade),
        .pronto      (pronto),
        .erro        (erro),
        .db_estado   (db_estado)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: pop the scoreboard on every pronto, check hold on every erro
    always @(negedge clock) begin
        logic [31:0] e;
        if (pronto || erro) begin
            chk("pronto_erro_excl", {31'd0, pronto & erro}, 32'd0);
        end
        if (pronto) begin
            pronto_cnt++;
            if (sb_q.size() == 0) begin
                chk("pronto_inesperado", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("temperatura", {16'd0, temperatura}, {16'd0, e[31:16]});
                chk("umidade", {16'd0, umidade}, {16'd0, e[15:0]});
                ult_temp = e[31:16];
                ult_umid = e[15:0];
            end
        end
        if (erro) begin
            erro_cnt++;
            chk("erro_temp_mantida", {16'd0, temperatura}, {16'd0, ult_temp});
            chk("erro_umid_mantida", {16'd0, umidade}, {16'd0, ult_umid});
        end
    end

    task automatic espera(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx_serial = 1'b0;
        espera(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            espera(CPB);
        end
        rx_serial = stop_ok;
        espera(CPB);
        if (!stop_ok) begin
            rx_serial = 1'b1;
            espera(CPB);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1);
        end
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_pronto_cnt"}, pronto_cnt, exp_pronto);
        chk({tag, "_erro_cnt"}, erro_cnt, exp_erro);
    endtask

    task automatic pacote(input string s, input logic [15:0] t, input logic [15:0] u);
        sb_q.push_back({t, u});
        exp_pronto++;
        send_str(s);
        espera(CPB);
        chk({s, "_sb_vazio"}, sb_q.size(), 32'd0);
        check_counts(s);
        chk({s, "_temp_final"}, {16'd0, temperatura}, {16'd0, t});
        chk({s, "_umid_final"}, {16'd0, umidade}, {16'd0, u});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_temp"}, {16'd0, temperatura}, 32'd0);
        chk({tag, "_umid"}, {16'd0, umidade}, 32'd0);
        chk({tag, "_pronto"}, {31'd0, pronto}, 32'd0);
        chk({tag, "_erro"}, {31'd0, erro}, 32'd0);
        chk({tag, "_estado"}, {28'd0, db_estado}, {28'd0, AGUARDA});
    endtask

    initial begin
        reset = 1'b0;
        rx_serial = 1'b1;
        espera(4);
        chk_reset("rst_inicial");
        reset = 1'b1;
        espera(2 * CPB);

        pacote("23451267", 16'h172D, 16'h0C43);

        // Reset in the middle of a packet and of a character
        send_str("12");
        rx_serial = 1'b0;
        espera(3 * CPB);
        reset = 1'b0;
        rx_serial = 1'b1;
        espera(3);
        chk_reset("rst_meio");
        ult_temp = 16'h0000;
        ult_umid = 16'h0000;
        reset = 1'b1;
        espera(12 * CPB);
        check_counts("pos_rst");
        chk("pos_rst_estado", {28'd0, db_estado}, {28'd0, AGUARDA});

        pacote("99999999", 16'h6363, 16'h6363);
        pacote("00000000", 16'h0000, 16'h0000);

        // Non-digit character aborts the partial packet
        send_str("23A");
        exp_erro++;
        espera(CPB);
        check_counts("nao_digito");
        pacote("11223344", 16'h0B16, 16'h212C);

        // Framing error on the 4th character
        send_str("567");
        send_byte(8'h38, 1'b0);
        exp_erro++;
        espera(CPB);
        check_counts("framing");
        pacote("87654321", 16'h5741, 16'h2B15);

        // Short low glitch must not look like a start bit
        rx_serial = 1'b0;
        espera(CPB / 4);
        rx_serial = 1'b1;
        espera(12 * CPB);
        check_counts("glitch");
        chk("glitch_estado", {28'd0, db_estado}, {28'd0, AGUARDA});
        pacote("10203040", 16'h0A14, 16'h1E28);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
